// File: rtl/pacman_catch_if.sv
// -----------------------------------------------------------------------------
// pacman_catch_if
// Groups the pacman/monster position inputs and the catch/life-sequence
// outputs of pacman_catch_ctrl.
//   master : game side; drives tick, start, p_x/p_y, m_x_bus/m_y_bus and
//            observes freeze, respawn, caught, hit_index, lives, game_over,
//            state
//   slave  : pacman_catch_ctrl; the mirror image of master
// Monster i occupies bits [i*COORD_W +: COORD_W] of m_x_bus and m_y_bus.
// -----------------------------------------------------------------------------
interface pacman_catch_if #(
    parameter int NUM_MON = 3,
    parameter int COORD_W = 9
);
    logic                         tick;
    logic                         start;
    logic [COORD_W-1:0]           p_x;
    logic [COORD_W-1:0]           p_y;
    logic [NUM_MON*COORD_W-1:0]   m_x_bus;
    logic [NUM_MON*COORD_W-1:0]   m_y_bus;
    logic                         freeze;
    logic                         respawn;
    logic                         caught;
    logic [2:0]                   hit_index;
    logic [1:0]                   lives;
    logic                         game_over;
    logic [2:0]                   state;

    modport master (
        output tick, start, p_x, p_y, m_x_bus, m_y_bus,
        input  freeze, respawn, caught, hit_index, lives, game_over, state
    );

    modport slave (
        input  tick, start, p_x, p_y, m_x_bus, m_y_bus,
        output freeze, respawn, caught, hit_index, lives, game_over, state
    );
endinterface

// File: rtl/pacman_catch_ctrl.sv
// -----------------------------------------------------------------------------
// pacman_catch_ctrl
// Detects a monster catching pacman and runs the life/death sequence
// (freeze, respawn, life decrement, game over). freeze and respawn gate the
// pacman and monster movers.
// Ports:
//   clk : system clock
//   rst : asynchronous, active-high reset
//   bus : pacman_catch_if.slave
//         in : tick (frame strobe), start (level), p_x/p_y, m_x_bus/m_y_bus
//         out: freeze, respawn (1-clk pulse), caught (1-clk pulse),
//              hit_index, lives, game_over, state
// Stage 1 registers a per-monster hit vector every clk; the FSM acts on it
// only on tick, so a hit reaches the FSM one clk after positions change.
// -----------------------------------------------------------------------------
module pacman_catch_ctrl #(
    parameter int NUM_MON       = 3,
    parameter int COORD_W       = 9,
    parameter int HIT_DIST      = 8,
    parameter int FREEZE_CYCLES = 60,
    parameter int LIVES_INIT    = 3
) (
    input  logic           clk,
    input  logic           rst,
    pacman_catch_if.slave  bus
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_PLAY    = 3'd1;
    localparam logic [2:0] ST_CAUGHT  = 3'd2;
    localparam logic [2:0] ST_RESPAWN = 3'd3;
    localparam logic [2:0] ST_OVER    = 3'd4;

    localparam logic [COORD_W:0] L_HIT_DIST = (COORD_W+1)'(HIT_DIST);
    localparam logic [7:0]       L_FRZ_LAST = 8'(FREEZE_CYCLES - 1);
    localparam logic [1:0]       L_LIVES    = 2'(LIVES_INIT);
    // Stale pipelined hits are ignored for this many clks after entering PLAY.
    localparam logic [1:0]       L_MASK     = 2'd2;

    logic [NUM_MON-1:0] w_hit_vec;
    logic [NUM_MON-1:0] r_hit_vec;
    logic [2:0]         w_hit_idx;

    logic [2:0]         r_state;
    logic               r_respawn;
    logic               r_caught;
    logic [2:0]         r_hit_index;
    logic [1:0]         r_lives;
    logic [7:0]         r_frz_cnt;
    logic [1:0]         r_mask;

    // Distances use one extra bit so |p - m| never wraps around 0/511.
    for (genvar g = 0; g < NUM_MON; g++) begin : g_dist
        logic [COORD_W:0] w_px, w_py, w_mx, w_my, w_dx, w_dy;

        assign w_px = {1'b0, bus.p_x};
        assign w_py = {1'b0, bus.p_y};
        assign w_mx = {1'b0, bus.m_x_bus[g*COORD_W +: COORD_W]};
        assign w_my = {1'b0, bus.m_y_bus[g*COORD_W +: COORD_W]};
        assign w_dx = (w_px >= w_mx) ? (w_px - w_mx) : (w_mx - w_px);
        assign w_dy = (w_py >= w_my) ? (w_py - w_my) : (w_my - w_py);
        assign w_hit_vec[g] = (w_dx < L_HIT_DIST) && (w_dy < L_HIT_DIST);
    end

    // Lowest-index monster wins: scan downward so lower indices overwrite.
    always_comb begin
        // NOTE: default assignment first so no path through the block leaves
        // w_hit_idx unassigned, which would otherwise infer a latch.
        w_hit_idx = 3'd0;
        for (int i = NUM_MON - 1; i >= 0; i--) begin
            if (r_hit_vec[i]) begin
                w_hit_idx = 3'(i);
            end
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit_vec <= '0;
        end else begin
            r_hit_vec <= w_hit_vec;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_respawn   <= 1'b0;
            r_caught    <= 1'b0;
            r_hit_index <= 3'd0;
            r_lives     <= 2'd0;
            r_frz_cnt   <= 8'd0;
            r_mask      <= 2'd0;
        end else begin
            r_respawn <= 1'b0;
            r_caught  <= 1'b0;

            case (r_state)
                ST_IDLE, ST_OVER: begin
                    if (bus.start) begin
                        r_lives   <= L_LIVES;
                        r_respawn <= 1'b1;
                        r_mask    <= L_MASK;
                        r_state   <= ST_PLAY;
                    end
                end

                ST_PLAY: begin
                    if (r_mask != 2'd0) begin
                        r_mask <= r_mask - 2'd1;
                    end else if (bus.tick && (|r_hit_vec)) begin
                        r_caught    <= 1'b1;
                        r_hit_index <= w_hit_idx;
                        r_lives     <= (r_lives != 2'd0) ? (r_lives - 2'd1) : 2'd0;
                        r_frz_cnt   <= 8'd0;
                        r_state     <= ST_CAUGHT;
                    end
                end

                ST_CAUGHT: begin
                    if (bus.tick) begin
                        if (r_frz_cnt == L_FRZ_LAST) begin
                            if (r_lives == 2'd0) begin
                                r_state <= ST_OVER;
                            end else begin
                                // Pulse is set on entry so it is high for
                                // exactly the one clk spent in RESPAWN.
                                r_respawn <= 1'b1;
                                r_state   <= ST_RESPAWN;
                            end
                        end else begin
                            r_frz_cnt <= r_frz_cnt + 8'd1;
                        end
                    end
                end

                ST_RESPAWN: begin
                    r_mask  <= L_MASK;
                    r_state <= ST_PLAY;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.freeze    = (r_state != ST_PLAY);
    assign bus.game_over = (r_state == ST_OVER);
    assign bus.respawn   = r_respawn;
    assign bus.caught    = r_caught;
    assign bus.hit_index = r_hit_index;
    assign bus.lives     = r_lives;
    assign bus.state     = r_state;

endmodule

// File: tb/tb_pacman_catch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pacman_catch_ctrl
// Self-checking bench for pacman_catch_ctrl (FREEZE_CYCLES overridden to 4).
// Expected catches (monster index, remaining lives) are queued when the
// overlapping positions are driven and popped when caught pulses.
// -----------------------------------------------------------------------------
module tb_pacman_catch_ctrl;

    localparam int NM = 3;
    localparam int CW = 9;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PLAY    = 3'd1;
    localparam logic [2:0] S_CAUGHT  = 3'd2;
    localparam logic [2:0] S_RESPAWN = 3'd3;
    localparam logic [2:0] S_OVER    = 3'd4;

    typedef struct {
        logic [2:0] idx;
        logic [1:0] lives;
    } exp_t;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;
    exp_t sb_q[$];

    pacman_catch_if #(.NUM_MON(NM), .COORD_W(CW)) bus ();

    pacman_catch_ctrl #(
        .NUM_MON(NM), .COORD_W(CW), .HIT_DIST(8), .FREEZE_CYCLES(4), .LIVES_INIT(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mon(input int i, input int x, input int y);
        bus.m_x_bus[i*CW +: CW] = CW'(x);
        bus.m_y_bus[i*CW +: CW] = CW'(y);
    endtask

    task automatic park_all();
        for (int i = 0; i < NM; i++) set_mon(i, 300 + i * 60, 450);
    endtask

    task automatic push_exp(input int idx, input int lives);
        exp_t e;
        e.idx   = 3'(idx);
        e.lives = 2'(lives);
        sb_q.push_back(e);
    endtask

    // One tick edge that must produce a catch matching the scoreboard head.
    task automatic tick_expect_catch(input string name);
        exp_t e;
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        e.idx = 3'd7;
        e.lives = 2'd3;
        if (sb_q.size() != 0) e = sb_q.pop_front();
        n_total++; if (bus.caught !== 1'b1) $display("FAIL %s_caught: got %0b want 1", name, bus.caught); else n_pass++;
        n_total++; if (bus.hit_index !== e.idx) $display("FAIL %s_hit_index: got %0d want %0d", name, bus.hit_index, e.idx); else n_pass++;
        n_total++; if (bus.lives !== e.lives) $display("FAIL %s_lives: got %0d want %0d", name, bus.lives, e.lives); else n_pass++;
        n_total++; if (bus.state !== S_CAUGHT || bus.freeze !== 1'b1) $display("FAIL %s_state: got %0d/%0b want %0d/1", name, bus.state, bus.freeze, S_CAUGHT); else n_pass++;
        step();
        n_total++; if (bus.caught !== 1'b0) $display("FAIL %s_caught_pulse: got %0b want 0", name, bus.caught); else n_pass++;
    endtask

    // One tick edge that must not produce a catch.
    task automatic tick_expect_none(input string name);
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        n_total++; if (bus.caught !== 1'b0 || bus.state !== S_PLAY) $display("FAIL %s: got caught=%0b state=%0d want 0/%0d", name, bus.caught, bus.state, S_PLAY); else n_pass++;
    endtask

    // From CAUGHT: 4 ticks (with idle clks between) end the freeze.
    task automatic freeze_sequence(input string name, input bit to_over);
        for (int i = 0; i < 3; i++) begin
            bus.tick = 1'b1;
            step();
            bus.tick = 1'b0;
            step();
        end
        n_total++; if (bus.state !== S_CAUGHT || bus.freeze !== 1'b1) $display("FAIL %s_hold: got state=%0d freeze=%0b want %0d/1", name, bus.state, bus.freeze, S_CAUGHT); else n_pass++;
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        if (to_over) begin
            n_total++; if (bus.state !== S_OVER || bus.game_over !== 1'b1 || bus.freeze !== 1'b1) $display("FAIL %s_over: got state=%0d go=%0b freeze=%0b want %0d/1/1", name, bus.state, bus.game_over, bus.freeze, S_OVER); else n_pass++;
            n_total++; if (bus.lives !== 2'd0 || bus.respawn !== 1'b0) $display("FAIL %s_over_lives: got lives=%0d respawn=%0b want 0/0", name, bus.lives, bus.respawn); else n_pass++;
        end else begin
            n_total++; if (bus.state !== S_RESPAWN || bus.respawn !== 1'b1 || bus.freeze !== 1'b1) $display("FAIL %s_respawn: got state=%0d respawn=%0b freeze=%0b want %0d/1/1", name, bus.state, bus.respawn, bus.freeze, S_RESPAWN); else n_pass++;
            step();
            n_total++; if (bus.state !== S_PLAY || bus.respawn !== 1'b0 || bus.freeze !== 1'b0) $display("FAIL %s_play: got state=%0d respawn=%0b freeze=%0b want %0d/0/0", name, bus.state, bus.respawn, bus.freeze, S_PLAY); else n_pass++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_total++; if (bus.state !== S_IDLE || bus.freeze !== 1'b1) $display("FAIL reset_state: got state=%0d freeze=%0b want 0/1", bus.state, bus.freeze); else n_pass++;
        n_total++; if (bus.respawn !== 1'b0 || bus.caught !== 1'b0 || bus.game_over !== 1'b0) $display("FAIL reset_pulses: got respawn=%0b caught=%0b go=%0b want 0/0/0", bus.respawn, bus.caught, bus.game_over); else n_pass++;
        n_total++; if (bus.lives !== 2'd0 || bus.hit_index !== 3'd0) $display("FAIL reset_lives: got lives=%0d idx=%0d want 0/0", bus.lives, bus.hit_index); else n_pass++;
        rst = 1'b0;
        step();
        n_total++; if (bus.state !== S_IDLE) $display("FAIL idle_hold: got %0d want 0", bus.state); else n_pass++;
    endtask

    task automatic test_start(input string name);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        n_total++; if (bus.respawn !== 1'b1 || bus.state !== S_PLAY || bus.freeze !== 1'b0) $display("FAIL %s_play: got respawn=%0b state=%0d freeze=%0b want 1/%0d/0", name, bus.respawn, bus.state, bus.freeze, S_PLAY); else n_pass++;
        n_total++; if (bus.lives !== 2'd3 || bus.game_over !== 1'b0) $display("FAIL %s_lives: got lives=%0d go=%0b want 3/0", name, bus.lives, bus.game_over); else n_pass++;
        step();
        n_total++; if (bus.respawn !== 1'b0) $display("FAIL %s_respawn_pulse: got %0b want 0", name, bus.respawn); else n_pass++;
    endtask

    task automatic test_game_one();
        // dx = 8 is just outside the catch radius.
        bus.p_x = 9'd84;
        bus.p_y = 9'd100;
        set_mon(0, 92, 100);
        step();
        tick_expect_none("dx8_no_catch");
        // Monster 1 at (90,104): dx=6, dy=4.
        set_mon(0, 300, 450);
        set_mon(1, 90, 104);
        push_exp(1, 2);
        step();
        tick_expect_catch("catch1");
        // start is ignored while CAUGHT.
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        n_total++; if (bus.state !== S_CAUGHT || bus.lives !== 2'd2) $display("FAIL start_in_caught: got state=%0d lives=%0d want %0d/2", bus.state, bus.lives, S_CAUGHT); else n_pass++;
        freeze_sequence("freeze1", 1'b0);
        // Monster 1 still overlaps: masked for exactly 2 clks, caught on the 3rd.
        tick_expect_none("mask1_a");
        tick_expect_none("mask1_b");
        push_exp(1, 1);
        tick_expect_catch("catch2_after_mask");
        freeze_sequence("freeze2", 1'b0);
        // dx = 7 is inside the radius; the stale monster-1 hit is masked.
        set_mon(1, 360, 450);
        set_mon(0, 91, 100);
        tick_expect_none("mask2_a");
        tick_expect_none("mask2_b");
        push_exp(0, 0);
        tick_expect_catch("dx7_catch");
        freeze_sequence("freeze3", 1'b1);
    endtask

    task automatic test_game_two();
        park_all();
        test_start("restart");
        // p_x=0 against m_x=508 must not wrap into a catch.
        bus.p_x = 9'd0;
        bus.p_y = 9'd100;
        set_mon(0, 508, 100);
        step();
        tick_expect_none("no_wrap");
        // Hit present but no tick: ignored.
        set_mon(0, 300, 450);
        set_mon(2, 5, 100);
        repeat (3) step();
        n_total++; if (bus.caught !== 1'b0 || bus.state !== S_PLAY) $display("FAIL no_tick_ignored: got caught=%0b state=%0d want 0/%0d", bus.caught, bus.state, S_PLAY); else n_pass++;
        push_exp(2, 2);
        tick_expect_catch("low_edge_catch");
        freeze_sequence("freeze4", 1'b0);
    endtask

    task automatic test_multi_hit();
        park_all();
        bus.p_x = 9'd200;
        bus.p_y = 9'd200;
        set_mon(0, 203, 198);
        set_mon(2, 197, 205);
        tick_expect_none("mask3_a");
        tick_expect_none("mask3_b");
        push_exp(0, 1);
        tick_expect_catch("multi_hit");
    endtask

    task automatic test_rst_mid_caught();
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        n_total++; if (bus.state !== S_CAUGHT) $display("FAIL pre_rst_state: got %0d want %0d", bus.state, S_CAUGHT); else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_total++; if (bus.state !== S_IDLE || bus.freeze !== 1'b1 || bus.lives !== 2'd0) $display("FAIL rst_mid_caught: got state=%0d freeze=%0b lives=%0d want 0/1/0", bus.state, bus.freeze, bus.lives); else n_pass++;
        n_total++; if (bus.hit_index !== 3'd0 || bus.game_over !== 1'b0 || bus.respawn !== 1'b0) $display("FAIL rst_mid_outputs: got idx=%0d go=%0b respawn=%0b want 0/0/0", bus.hit_index, bus.game_over, bus.respawn); else n_pass++;
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        n_pass       = 0;
        n_total      = 0;
        rst          = 1'b1;
        bus.tick     = 1'b0;
        bus.start    = 1'b0;
        bus.p_x      = 9'd84;
        bus.p_y      = 9'd100;
        bus.m_x_bus  = '0;
        bus.m_y_bus  = '0;
        park_all();

        test_reset();
        test_start("start");
        test_game_one();
        test_game_two();
        test_multi_hit();
        test_rst_mid_caught();

        n_total++; if (sb_q.size() != 0) $display("FAIL scoreboard_drain: got %0d left want 0", sb_q.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pacman_catch_ctrl.md
Name: pacman_catch_ctrl

Overview:
Downstream consumer of the monster position outputs (m_x/m_y per monster) and the pacman position (p_x/p_y). Detects when any monster catches pacman, then runs the life/death sequence: freeze, respawn, life decrement and game over. Its freeze and respawn outputs gate the pacman and monster movement stages. It sits between the movers and the top-level game/display logic.

Parameters:
NUM_MON, 3, number of monsters checked; valid range 1..7.
COORD_W, 9, coordinate width; matches the 9-bit p_x/m_x buses.
HIT_DIST, 8, a catch requires |dx| < HIT_DIST and |dy| < HIT_DIST.
FREEZE_CYCLES, 60, number of tick pulses spent in CAUGHT before respawn; valid range 1..255.
LIVES_INIT, 3, lives loaded on start; valid range 1..3.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
tick  input  1  one-cycle movement/frame strobe; catch checks and freeze counting happen only on tick
start  input  1  level; starts or restarts a game from IDLE or OVER
p_x  input  COORD_W  pacman x
p_y  input  COORD_W  pacman y
m_x_bus  input  NUM_MON*COORD_W  monster x values; monster i occupies bits [i*COORD_W +: COORD_W]
m_y_bus  input  NUM_MON*COORD_W  monster y values; same packing as m_x_bus
freeze  output  1  high = movers must hold position
respawn  output  1  one-cycle pulse; movers reload their start positions
caught  output  1  one-cycle pulse on catch detection
hit_index  output  3  index of the catching monster; held until the next catch
lives  output  2  remaining lives
game_over  output  1  high while in OVER
state  output  3  current FSM state, for debug/display

Behaviour:
- Reset (async, rst=1): state=IDLE, freeze=1, respawn=0, caught=0, hit_index=0, lives=0, game_over=0, freeze counter=0.
- Pipeline stage 1 (registered every clk):
  - per monster: dx = |p_x - m_x[i]| and dy = |p_y - m_y[i]|, computed unsigned with COORD_W+1-bit intermediates, so there is no wrap at 0/511.
  - hit_vec[i] = (dx < HIT_DIST) && (dy < HIT_DIST).
  - A hit therefore reaches the FSM 1 clk after the positions change.
- Priority: if several hit_vec bits are set, the lowest index wins hit_index.
- FSM:
  - IDLE: freeze=1. When start=1, load lives=LIVES_INIT, pulse respawn for 1 clk, go to PLAY.
  - PLAY: freeze=0. On a clk with tick=1 and |hit_vec:
    - pulse caught for 1 clk; set hit_index;
    - lives <= lives-1;
    - clear the freeze counter; go to CAUGHT.
    - hit_vec is ignored when tick=0.
  - CAUGHT: freeze=1. The counter increments on each tick. When the counter reaches FREEZE_CYCLES-1 on a tick:
    - if lives==0, go to OVER;
    - otherwise go to RESPAWN.
  - RESPAWN: respawn=1 for exactly 1 clk, freeze=1, then go to PLAY.
    - Catch detection is masked for 2 clk after entry to PLAY, so that stale pipelined hits do not retrigger.
  - OVER: freeze=1, game_over=1. When start=1, behave as in IDLE (reload lives, pulse respawn, go to PLAY) and clear game_over.
- Simultaneous events:
  - start is ignored in PLAY/CAUGHT/RESPAWN.
  - A hit and a tick in the same cycle as the PLAY-entry mask count as no hit.
- Lives arithmetic: saturates at 0; no underflow.
- rst mid-sequence (any state): immediate return to the reset values; the respawn pulse is cut.
- State encoding (state output): IDLE=0, PLAY=1, CAUGHT=2, RESPAWN=3, OVER=4.

Test Plan:
1. Reset then start=1 for 1 clk -> respawn pulse 1 clk; lives=3, state=PLAY, freeze=0.
2. PLAY, p=(84,100), monster1=(90,104), tick -> 1 clk later caught=1, hit_index=1, lives=2, state=CAUGHT.
3. Boundary: monster at dx=8, dy=0 with tick -> no catch. With dx=7 -> catch. With p_x=0, m_x=5 -> catch, no wrap.
4. Monsters 0 and 2 both overlapping on the same tick -> hit_index=0 and lives decremented by exactly 1.
5. CAUGHT with FREEZE_CYCLES=4 -> exactly 4 ticks later RESPAWN (respawn 1 clk), then PLAY. A monster still overlapping during the 2-clk mask -> no catch.
6. Three catches -> lives 3→0, state=OVER, game_over=1. Then start -> lives=3, PLAY. A second test asserts rst mid-CAUGHT -> IDLE immediately.
